blink_decoder: RTL

Receiver for the pin-scan blink code: samples a single line driven by a blinking LED or a looped-back pin and recovers the 7-bit column and row numbers carried by each frame. A frame is a fast-toggle preamble, then `col` 8-high/8-low pulses, a long low gap, then `row` pulses, then a long low gap. The block sits on the bench-side board and reports each decoded (col, row) pair with a one-cycle strobe, so pin mappings can be logged automatically.

---
 rtl/blink_decoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/blink_decoder.sv
// Pin-scan blink code receiver: decodes (col,row) frames from a single blink line.
// Define BLINK_DECODER_SYNC_EN to put a 2-flop synchroniser in front of the sampler.
module blink_decoder #(
  parameter int PRE_MIN   = 8,
  parameter int PULSE_MIN = 4,
  parameter int PULSE_MAX = 12,
  parameter int GAP_MIN   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig,
  output logic [6:0] col,
  output logic [6:0] row,
  output logic       valid,
  output logic       err
);

  localparam int               TOG_W       = $clog2(PRE_MIN + 1);
  localparam logic [TOG_W-1:0] TOG_LAST    = TOG_W'(PRE_MIN - 1);
  localparam logic [TOG_W-1:0] TOG_ONE     = TOG_W'(1);
  localparam logic [6:0]       PULSE_MIN_C = 7'(PULSE_MIN);
  localparam logic [6:0]       PULSE_MAX_C = 7'(PULSE_MAX);
  localparam logic [6:0]       STUCK_C     = 7'(PULSE_MAX + 1);
  localparam logic [6:0]       GAP_MIN_C   = 7'(GAP_MIN);

  typedef enum logic [1:0] {IDLE, PRE, COL, ROW} state_t;

  logic s_src;
`ifdef BLINK_DECODER_SYNC_EN
  logic [1:0] sync_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_reg <= 2'b00;
    else       sync_reg <= {sync_reg[0], sig};
  end
  assign s_src = sync_reg[1];
`else
  assign s_src = sig;
`endif

  logic       s_reg, s_prev_reg;
  logic [6:0] high_run_reg, low_run_reg;
  logic [6:0] high_run_next, low_run_next;
  logic       low_clr;
  logic       toggle, fall;

  assign toggle = s_reg ^ s_prev_reg;
  assign fall   = s_prev_reg & ~s_reg;

  // Run lengths include the current sample of s; each saturates at 127.
  always_comb begin
    high_run_next = 7'd0;
    low_run_next  = 7'd0;
    if (s_reg) high_run_next = (high_run_reg == 7'h7f) ? 7'h7f : high_run_reg + 7'd1;
    else       low_run_next  = (low_run_reg  == 7'h7f) ? 7'h7f : low_run_reg  + 7'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_reg        <= 1'b0;
      s_prev_reg   <= 1'b0;
      high_run_reg <= 7'd0;
      low_run_reg  <= 7'd0;
    end else begin
      s_reg        <= s_src;
      s_prev_reg   <= s_reg;
      high_run_reg <= high_run_next;
      low_run_reg  <= low_clr ? 7'd0 : low_run_next;
    end
  end

  state_t           state_reg, state_next;
  logic [TOG_W-1:0] tog_cnt_reg, tog_cnt_next;
  logic [7:0]       col_cnt_reg, col_cnt_next;
  logic [7:0]       row_cnt_reg, row_cnt_next;
  logic [6:0]       col_reg, col_next;
  logic [6:0]       row_reg, row_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic             pulse_ok;

  assign pulse_ok = (high_run_reg >= PULSE_MIN_C) && (high_run_reg <= PULSE_MAX_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      tog_cnt_reg <= '0;
      col_cnt_reg <= 8'd0;
      row_cnt_reg <= 8'd0;
      col_reg     <= 7'd0;
      row_reg     <= 7'd0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tog_cnt_reg <= tog_cnt_next;
      col_cnt_reg <= col_cnt_next;
      row_cnt_reg <= row_cnt_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  // Bit 7 of a field count is the overflow flag: the count parks at 128 once set,
  // and the frame is only rejected when its trailing gap is seen.
  always_comb begin
    state_next   = state_reg;
    tog_cnt_next = tog_cnt_reg;
    col_cnt_next = col_cnt_reg;
    row_cnt_next = row_cnt_reg;
    col_next     = col_reg;
    row_next     = row_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    low_clr      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!toggle) begin
          tog_cnt_next = '0;
        end else if (tog_cnt_reg == TOG_LAST) begin
          tog_cnt_next = '0;
          state_next   = PRE;
        end else begin
          tog_cnt_next = tog_cnt_reg + TOG_ONE;
        end
      end
      PRE: begin
        if (!toggle) begin
          state_next   = COL;
          col_cnt_next = 8'd0;
          row_cnt_next = 8'd0;
        end
      end
      COL, ROW: begin
        if (fall) begin
          if (!pulse_ok) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else if (state_reg == COL) begin
            if (!col_cnt_reg[7]) col_cnt_next = col_cnt_reg + 8'd1;
          end else begin
            if (!row_cnt_reg[7]) row_cnt_next = row_cnt_reg + 8'd1;
          end
        end else if (s_reg && (high_run_next == STUCK_C)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (!s_reg && (low_run_next == GAP_MIN_C)) begin
          if (state_reg == COL) begin
            // Restart the gap count so the row field needs its own full gap.
            state_next = ROW;
            low_clr    = 1'b1;
          end else if (col_cnt_reg[7] || row_cnt_reg[7]) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            col_next   = col_cnt_reg[6:0];
            row_next   = row_cnt_reg[6:0];
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign col   = col_reg;
  assign row   = row_reg;
  assign valid = valid_reg;
  assign err   = err_reg;

endmodule
